// File: rtl/des_word_aligner.sv
// Word aligner behind the 1-to-2 deserializer: finds a sync word at any bit offset,
// confirms it on consecutive word slots, then emits aligned words once per slot.
module des_word_aligner #(
  parameter int                   WordWidth   = 16,
  parameter logic [WordWidth-1:0] SyncPattern = 16'hA5C3,
  parameter int                   VerifyCount = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [1:0]                   i_dat,
  input  logic                         i_realign,
  output logic [WordWidth-1:0]         o_word,
  output logic                         o_valid,
  output logic                         o_locked,
  output logic [$clog2(WordWidth)-1:0] o_offset
);

  localparam int OffW = $clog2(WordWidth);
  localparam int CntW = $clog2(WordWidth / 2);
  localparam logic [CntW-1:0] SlotLast     = CntW'(WordWidth / 2 - 1);
  localparam logic [3:0]      VerifyTarget = 4'(VerifyCount);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Only the 2W-1 newest bits are ever visible through a window, so the two
  // oldest history bits are not stored.
  logic [2*WordWidth-4:0] hist_r;
  logic [2*WordWidth-2:0] hist_s;
  state_t                 state_r, state_s;
  logic [CntW-1:0]        cnt_r, cnt_s;
  logic [3:0]             match_r, match_s, match_inc_s;
  logic [WordWidth-1:0]   hit_vec_s;
  logic                   hit_s;
  logic [OffW-1:0]        hit_off_s;
  logic [WordWidth-1:0]   win_s;
  logic                   slot_edge_s;
  logic [WordWidth-1:0]   word_s;
  logic                   valid_s;
  logic [OffW-1:0]        offset_s;

  function automatic logic [OffW-1:0] lowest_hit(input logic [WordWidth-1:0] vec);
    lowest_hit = '0;
    for (int k = WordWidth - 1; k >= 0; k--) begin
      if (vec[k]) lowest_hit = OffW'(k);
    end
  endfunction

  assign hist_s = {hist_r, i_dat[0], i_dat[1]};

  for (genvar k = 0; k < WordWidth; k++) begin : g_win
    assign hit_vec_s[k] = (hist_s[k +: WordWidth] == SyncPattern);
  end

  assign hit_s       = |hit_vec_s;
  assign hit_off_s   = lowest_hit(hit_vec_s);
  assign win_s       = hist_s[o_offset +: WordWidth];
  assign slot_edge_s = (cnt_r == SlotLast);
  assign match_inc_s = match_r + 4'd1;

  // Next-state, slot timing and output word selection.
  always_comb begin
    state_s  = state_r;
    cnt_s    = slot_edge_s ? '0 : cnt_r + CntW'(1);
    match_s  = match_r;
    offset_s = o_offset;
    word_s   = o_word;
    valid_s  = 1'b0;
    if (i_realign) begin
      state_s = SEARCH;
      match_s = 4'd0;
    end else begin
      case (state_r)
        SEARCH: begin
          if (hit_s) begin
            offset_s = hit_off_s;
            cnt_s    = '0;
            if (VerifyTarget == 4'd1) begin
              state_s = LOCKED;
            end else begin
              state_s = VERIFY;
              match_s = 4'd1;
            end
          end else begin
            state_s = SEARCH;
          end
        end
        VERIFY: begin
          if (slot_edge_s) begin
            if (win_s == SyncPattern) begin
              match_s = match_inc_s;
              state_s = (match_inc_s == VerifyTarget) ? LOCKED : VERIFY;
            end else begin
              state_s = SEARCH;
              match_s = 4'd0;
            end
          end else begin
            state_s = VERIFY;
          end
        end
        LOCKED: begin
          if (slot_edge_s) begin
            word_s  = win_s;
            valid_s = 1'b1;
          end else begin
            valid_s = 1'b0;
          end
        end
        default: begin
          state_s = SEARCH;
          match_s = 4'd0;
        end
      endcase
    end
  end

  // State, history and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hist_r   <= '0;
      state_r  <= SEARCH;
      cnt_r    <= '0;
      match_r  <= 4'd0;
      o_word   <= '0;
      o_valid  <= 1'b0;
      o_locked <= 1'b0;
      o_offset <= '0;
    end else begin
      hist_r   <= hist_s[2*WordWidth-4:0];
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      match_r  <= match_s;
      o_word   <= word_s;
      o_valid  <= valid_s;
      o_locked <= (state_s == LOCKED);
      o_offset <= offset_s;
    end
  end

endmodule

// File: tb/tb_des_word_aligner.sv
// Self-checking bench for des_word_aligner: table of bit-stream scenarios with a
// scoreboard of expected aligned words, plus reset corner cases.
module tb_des_word_aligner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  dat = 2'b00;
  logic        realign = 1'b0;
  logic [15:0] word;
  logic        valid;
  logic        locked;
  logic [3:0]  offset;

  des_word_aligner #(
    .WordWidth  (16),
    .SyncPattern(16'hA5C3),
    .VerifyCount(3)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_dat    (dat),
    .i_realign(realign),
    .o_word   (word),
    .o_valid  (valid),
    .o_locked (locked),
    .o_offset (offset)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         junk_n;
    logic [7:0] junk;
    string      pat;
    int         mid_n;
    logic [7:0] mid;
    int         realign_at;
    int         ls0;
    int         off0;
    int         ls1;
    int         off1;
    int         ncyc;
  } scen_t;

  typedef struct {
    int          cyc;
    logic [15:0] word;
  } exp_t;

  scen_t tbl [5];
  exp_t  sb_q [$];
  logic  sbits [0:1023];
  int    slen;
  int    n_checks = 0;
  int    n_fail = 0;
  string cur = "reset";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", cur, name, act, exp, $time);
    end
  endtask

  function automatic scen_t mk(input string name, input int jn, input logic [7:0] jb,
                               input string pat, input int mn, input logic [7:0] mb,
                               input int ra, input int ls0, input int off0,
                               input int ls1, input int off1, input int ncyc);
    scen_t s;
    s.name = name; s.junk_n = jn; s.junk = jb; s.pat = pat; s.mid_n = mn; s.mid = mb;
    s.realign_at = ra; s.ls0 = ls0; s.off0 = off0; s.ls1 = ls1; s.off1 = off1; s.ncyc = ncyc;
    return s;
  endfunction

  task automatic add_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sbits[slen] = v[i];
      slen++;
    end
  endtask

  function automatic logic get_bit(input int idx);
    if (idx < 0 || idx >= slen) return 1'b0;
    return sbits[idx];
  endfunction

  // Word whose last bit sits 'off' bits before the newest bit captured at cycle t.
  function automatic logic [15:0] exp_word(input int t, input int off);
    logic [15:0] w;
    int e;
    e = 2 * t + 1 - off;
    for (int i = 0; i < 16; i++) w[i] = get_bit(e - i);
    return w;
  endfunction

  // S=sync, a=1234, b=BEEF, c=5A5A, z=0000, |=mid junk bits.
  task automatic build(input scen_t s);
    slen = 0;
    add_bits(16'(s.junk), s.junk_n);
    for (int i = 0; i < s.pat.len(); i++) begin
      case (s.pat[i])
        "S":     add_bits(16'hA5C3, 16);
        "a":     add_bits(16'h1234, 16);
        "b":     add_bits(16'hBEEF, 16);
        "c":     add_bits(16'h5A5A, 16);
        "z":     add_bits(16'h0000, 16);
        "|":     add_bits(16'(s.mid), s.mid_n);
        default: add_bits(16'h0000, 16);
      endcase
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    realign = 1'b0;
    repeat (3) begin
      dat = 2'($urandom_range(0, 3));
      @(posedge clk);
    end
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_scen(input int si, input int ncyc);
    scen_t       s;
    exp_t        e;
    logic [15:0] last_w;
    bit          lk0, lk1;
    s = tbl[si];
    cur = s.name;
    build(s);
    sb_q.delete();
    last_w = 16'h0000;
    for (int t = 0; t < ncyc; t++) begin
      dat = {get_bit(2 * t + 1), get_bit(2 * t)};
      realign = (t == s.realign_at);
      lk0 = (s.ls0 >= 0) && (t >= s.ls0) && ((s.realign_at < 0) || (t < s.realign_at));
      lk1 = (s.ls1 >= 0) && (t >= s.ls1);
      if (lk0 && t > s.ls0 && ((t - s.ls0) % 8 == 0)) begin
        e.cyc = t; e.word = exp_word(t, s.off0); last_w = e.word; sb_q.push_back(e);
      end
      if (lk1 && t > s.ls1 && ((t - s.ls1) % 8 == 0)) begin
        e.cyc = t; e.word = exp_word(t, s.off1); last_w = e.word; sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      check("locked", 32'(locked), 32'(lk0 || lk1));
      if (lk0 || lk1) check("offset", 32'(offset), 32'(lk0 ? s.off0 : s.off1));
      if (t == s.realign_at) begin
        check("realign_offset_hold", 32'(offset), 32'(s.off0));
        check("realign_word_hold", 32'(word), 32'(last_w));
      end
      if (valid) begin
        if (sb_q.size() == 0) begin
          check("spurious_valid", 32'(valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("word", 32'(word), 32'(e.word));
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc == t) begin
        check("missing_valid", 32'(valid), 32'd1);
        void'(sb_q.pop_front());
      end
    end
    realign = 1'b0;
  endtask

  initial begin
    tbl[0] = mk("aligned",     0, 8'h00, "SSSab",      0, 8'h00, -1, 23, 0, -1, 0, 50);
    tbl[1] = mk("misaligned5", 5, 8'h16, "SSSab",      0, 8'h00, -1, 26, 1, -1, 0, 52);
    tbl[2] = mk("misaligned2", 2, 8'h03, "SSSab",      0, 8'h00, -1, 24, 0, -1, 0, 50);
    tbl[3] = mk("verify_fail", 0, 8'h00, "SSzSSSab",   0, 8'h00, -1, 47, 0, -1, 0, 66);
    tbl[4] = mk("realign",     0, 8'h00, "SSSa|SSSbc", 3, 8'h03, 35, 23, 0, 57, 1, 76);

    // Reset held with random input, then 64 quiet cycles.
    rst_n = 1'b0;
    repeat (4) begin
      dat = 2'($urandom_range(0, 3));
      @(posedge clk);
    end
    #1;
    check("rst_word", 32'(word), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_offset", 32'(offset), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dat = 2'b00;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      check("idle_valid", 32'(valid), 32'd0);
      check("idle_locked", 32'(locked), 32'd0);
    end
    check("idle_word", 32'(word), 32'd0);
    check("idle_offset", 32'(offset), 32'd0);

    for (int si = 0; si < 5; si++) begin
      apply_reset();
      run_scen(si, tbl[si].ncyc);
    end

    // Asynchronous reset right after a valid strobe, mid-cycle.
    apply_reset();
    run_scen(0, 32);
    cur = "reset_mid_lock";
    check("pre_reset_valid", 32'(valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_locked", 32'(locked), 32'd0);
    check("async_valid", 32'(valid), 32'd0);
    check("async_word", 32'(word), 32'd0);
    check("async_offset", 32'(offset), 32'd0);
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_scen(0, tbl[0].ncyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
